// File: rtl/ram_buffer_ctrl_pkg.sv
// Shared types and constants for the ram_buffer read sequencer.
// Holds the FSM encoding, feature-map size table and default kernel size.
package ram_buffer_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WLOAD = 3'd1,
      S_GAP   = 3'd2,
      S_FMAP  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int         KERNEL_TAPS_DEF = 25;
   localparam logic [2:0] MODE_MAX        = 3'd4;

   localparam logic [4:0] FMAP_SIZE_0 = 5'd28;
   localparam logic [4:0] FMAP_SIZE_1 = 5'd24;
   localparam logic [4:0] FMAP_SIZE_2 = 5'd12;
   localparam logic [4:0] FMAP_SIZE_3 = 5'd8;
   localparam logic [4:0] FMAP_SIZE_4 = 5'd4;

   function automatic logic [4:0] fmap_size(input logic [2:0] mode);
      logic [4:0] size;
      case (mode)
         3'd0:    size = FMAP_SIZE_0;
         3'd1:    size = FMAP_SIZE_1;
         3'd2:    size = FMAP_SIZE_2;
         3'd3:    size = FMAP_SIZE_3;
         default: size = FMAP_SIZE_4;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/ram_buffer_ctrl_if.sv
// Control and ram_buffer-facing signals of the read sequencer.
// i_* are driven by the layer controller, o_* by the sequencer.
interface ram_buffer_ctrl_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  i_start;
   logic                  i_abort;
   logic                  i_stall;
   logic [2:0]            i_mode_in;
   logic [ADDR_WIDTH-1:0] i_weight_base;
   logic [ADDR_WIDTH-1:0] i_fmap_base;

   logic [ADDR_WIDTH-1:0] o_read_addr;
   logic                  o_en;
   logic                  o_WorI;
   logic [2:0]            o_mode;
   logic [4:0]            o_row_idx;
   logic [4:0]            o_col_idx;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_err;

   modport master (
      output i_start, i_abort, i_stall, i_mode_in, i_weight_base, i_fmap_base,
      input  o_read_addr, o_en, o_WorI, o_mode, o_row_idx, o_col_idx,
             o_busy, o_done, o_err
   );

   modport slave (
      input  i_start, i_abort, i_stall, i_mode_in, i_weight_base, i_fmap_base,
      output o_read_addr, o_en, o_WorI, o_mode, o_row_idx, o_col_idx,
             o_busy, o_done, o_err
   );
endinterface

// File: rtl/ram_buffer_ctrl_raster_addr_gen.sv
// Row/column raster counter with a running linear address (base + row*cols + col).
// Registered outputs; clr > load > step, otherwise holds.
module raster_addr_gen #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_load,
   input  logic                  i_step,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [4:0]            i_cols,
   input  logic [4:0]            i_rows,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [4:0]            o_row,
   output logic [4:0]            o_col,
   output logic                  o_last
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [4:0]            r_row;
   logic [4:0]            r_col;
   logic                  w_col_wrap;

   assign w_col_wrap = (r_col == i_cols - 5'd1);

   // Raster order is contiguous, so the address is a plain running increment.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_addr <= '0;
         r_row  <= '0;
         r_col  <= '0;
      end else if (i_load) begin
         r_addr <= i_base;
         r_row  <= '0;
         r_col  <= '0;
      end else if (i_step) begin
         r_addr <= r_addr + ADDR_ONE;
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= r_row + 5'd1;
         end else begin
            r_col <= r_col + 5'd1;
         end
      end
   end

   assign o_addr = r_addr;
   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = w_col_wrap && (r_row == i_rows - 5'd1);

endmodule

// File: rtl/ram_buffer_ctrl.sv
// Sequences ram_buffer reads: weight preload, one-cycle gap, feature-map raster, drain, done.
// First read one cycle after start; stall withholds the next read and holds address/counters.
module ram_buffer_ctrl
   import ram_buffer_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int KERNEL_TAPS  = KERNEL_TAPS_DEF,
   parameter int DRAIN_CYCLES = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   ram_buffer_ctrl_if.slave bus
);
   state_t                r_state, w_state_nxt;
   logic                  r_en, w_en_nxt;
   logic                  r_wori, w_wori_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_err, w_err_nxt;
   logic [2:0]            r_mode, w_mode_nxt;
   logic [ADDR_WIDTH-1:0] r_fbase, w_fbase_nxt;
   logic [7:0]            r_drain, w_drain_nxt;

   logic                  w_g_clr, w_g_load, w_g_step;
   logic [ADDR_WIDTH-1:0] w_g_base;
   logic [4:0]            w_size, w_cols, w_rows;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [4:0]            w_row, w_col;
   logic                  w_last;

   assign w_size = fmap_size(r_mode);
   // The weight phase reuses the raster counter as a single row of KERNEL_TAPS.
   assign w_cols = (r_state == S_WLOAD) ? 5'(KERNEL_TAPS) : w_size;
   assign w_rows = (r_state == S_WLOAD) ? 5'd1 : w_size;

   raster_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_g_clr),
      .i_load (w_g_load),
      .i_step (w_g_step),
      .i_base (w_g_base),
      .i_cols (w_cols),
      .i_rows (w_rows),
      .o_addr (w_addr),
      .o_row  (w_row),
      .o_col  (w_col),
      .o_last (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_en    <= 1'b0;
         r_wori  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_mode  <= '0;
         r_fbase <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_en    <= w_en_nxt;
         r_wori  <= w_wori_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_mode  <= w_mode_nxt;
         r_fbase <= w_fbase_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   // Next-cycle values: the generator always holds the most recently issued address.
   always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = 1'b0;
      w_wori_nxt  = r_wori;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_mode_nxt  = r_mode;
      w_fbase_nxt = r_fbase;
      w_drain_nxt = r_drain;
      w_g_clr     = 1'b0;
      w_g_load    = 1'b0;
      w_g_step    = 1'b0;
      w_g_base    = r_fbase;

      if (bus.i_abort) begin
         w_state_nxt = S_IDLE;
         w_wori_nxt  = 1'b0;
         w_busy_nxt  = 1'b0;
         w_drain_nxt = '0;
         w_g_clr     = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  w_mode_nxt  = bus.i_mode_in;
                  w_fbase_nxt = bus.i_fmap_base;
                  if (bus.i_mode_in > MODE_MAX) begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                     w_err_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = S_WLOAD;
                     w_en_nxt    = 1'b1;
                     w_wori_nxt  = 1'b1;
                     w_busy_nxt  = 1'b1;
                     w_g_load    = 1'b1;
                     w_g_base    = bus.i_weight_base;
                  end
               end
            end
            S_WLOAD: begin
               if (w_last) begin
                  w_state_nxt = S_GAP;
                  w_wori_nxt  = 1'b0;
                  w_g_load    = 1'b1;
               end else if (!bus.i_stall) begin
                  w_en_nxt = 1'b1;
                  w_g_step = 1'b1;
               end
            end
            S_GAP: begin
               w_state_nxt = S_FMAP;
               w_en_nxt    = 1'b1;
            end
            S_FMAP: begin
               if (w_last) begin
                  w_state_nxt = S_DRAIN;
                  w_drain_nxt = '0;
               end else if (!bus.i_stall) begin
                  w_en_nxt = 1'b1;
                  w_g_step = 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_drain == 8'(DRAIN_CYCLES - 1)) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_drain_nxt = r_drain + 8'd1;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_read_addr = w_addr;
   assign bus.o_en        = r_en;
   assign bus.o_WorI      = r_wori;
   assign bus.o_mode      = r_mode;
   assign bus.o_row_idx   = w_row;
   assign bus.o_col_idx   = w_col;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_err       = r_err;

endmodule

// File: tb/tb_ram_buffer_ctrl.sv
// Directed bench for ram_buffer_ctrl: expected reads queued at start, popped as en pulses appear.
// Covers reset, all sizes, stall, illegal mode, abort/restart, ignored start and address wrap.
module tb_ram_buffer_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ram_buffer_ctrl_if #(.ADDR_WIDTH(10)) bus ();

   ram_buffer_ctrl #(
      .ADDR_WIDTH   (10),
      .KERNEL_TAPS  (25),
      .DRAIN_CYCLES (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic       wori;
      logic [9:0] addr;
      logic [4:0] row;
      logic [4:0] col;
   } rd_t;

   rd_t        sb[$];
   int         total = 0;
   int         bad   = 0;
   int         cyc;
   int         n_fmap;
   int         stall_pix;
   int         abort_pix;
   int         st_left;
   int         chk_left;
   logic [9:0] held;
   bit         saw_done;
   bit         abort_hit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int size_of(input logic [2:0] md);
      case (md)
         3'd0:    return 28;
         3'd1:    return 24;
         3'd2:    return 12;
         3'd3:    return 8;
         3'd4:    return 4;
         default: return 0;
      endcase
   endfunction

   // One clock: sample just after the edge, score any read, then drive stall for the next edge.
   task automatic tick();
      rd_t e;
      int  pix;
      @(posedge clk);
      #1;
      cyc++;
      if (chk_left > 0) begin
         check("stall_en", bus.o_en, 0);
         check("stall_addr", bus.o_read_addr, held);
         chk_left--;
      end else if (bus.o_en === 1'b1) begin
         check("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("read_wori", bus.o_WorI, e.wori);
            check("read_addr", bus.o_read_addr, e.addr);
            if (!e.wori) begin
               check("row_idx", bus.o_row_idx, e.row);
               check("col_idx", bus.o_col_idx, e.col);
               pix = n_fmap;
               n_fmap++;
               if (pix == stall_pix) begin
                  st_left  = 3;
                  chk_left = 3;
                  held     = bus.o_read_addr;
               end
               if (pix == abort_pix) abort_hit = 1'b1;
            end
         end
      end
      if (bus.o_done === 1'b1) saw_done = 1'b1;
      bus.i_stall = (st_left > 0);
      if (st_left > 0) st_left--;
   endtask

   task automatic run_seq(input string nm, input logic [2:0] md, input logic [9:0] wb,
                          input logic [9:0] fb, input int spix, input int apix,
                          input bit extra_start, input int exp_done, input bit exp_err);
      int   s;
      logic noise;
      rd_t  e;
      s         = size_of(md);
      sb.delete();
      n_fmap    = 0;
      stall_pix = spix;
      abort_pix = apix;
      abort_hit = 1'b0;
      saw_done  = 1'b0;
      st_left   = 0;
      chk_left  = 0;
      if (md <= 3'd4) begin
         for (int k = 0; k < 25; k++) begin
            e.wori = 1'b1; e.addr = wb + 10'(k); e.row = 5'd0; e.col = 5'(k);
            sb.push_back(e);
         end
         for (int r = 0; r < s; r++) begin
            for (int c = 0; c < s; c++) begin
               e.wori = 1'b0; e.addr = fb + 10'(r * s + c); e.row = 5'(r); e.col = 5'(c);
               sb.push_back(e);
            end
         end
      end
      bus.i_mode_in     = md;
      bus.i_weight_base = wb;
      bus.i_fmap_base   = fb;
      bus.i_start       = 1'b1;
      cyc               = 0;
      for (int t = 0; t < 2000 && !saw_done && !abort_hit; t++) begin
         tick();
         bus.i_start = extra_start && (cyc == 3 || cyc == 300);
         if (cyc == 1) check({nm, "_busy_c1"}, bus.o_busy, (md <= 3'd4));
      end
      bus.i_start = 1'b0;
      if (abort_hit) begin
         bus.i_abort = 1'b1;
         tick();
         bus.i_abort = 1'b0;
         check({nm, "_en"}, bus.o_en, 0);
         check({nm, "_busy"}, bus.o_busy, 0);
         check({nm, "_done"}, bus.o_done, 0);
         sb.delete();
         noise = 1'b0;
         for (int t = 0; t < 8; t++) begin
            tick();
            noise = noise | bus.o_done | bus.o_en | bus.o_busy | bus.o_err;
         end
         check({nm, "_quiet"}, noise, 0);
      end else begin
         check({nm, "_done_seen"}, saw_done, 1);
         check({nm, "_done_cycle"}, cyc, exp_done);
         check({nm, "_err"}, bus.o_err, exp_err);
         check({nm, "_busy_at_done"}, bus.o_busy, 0);
         check({nm, "_mode"}, bus.o_mode, md);
         check({nm, "_reads_left"}, sb.size(), 0);
         tick();
         check({nm, "_done_pulse"}, bus.o_done, 0);
         check({nm, "_err_pulse"}, bus.o_err, 0);
         check({nm, "_busy_after"}, bus.o_busy, 0);
         check({nm, "_mode_held"}, bus.o_mode, md);
      end
   endtask

   initial begin
      bus.i_start       = 1'b0;
      bus.i_abort       = 1'b0;
      bus.i_stall       = 1'b0;
      bus.i_mode_in     = 3'd0;
      bus.i_weight_base = '0;
      bus.i_fmap_base   = '0;
      cyc               = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_read_addr", bus.o_read_addr, 0);
      check("rst_en", bus.o_en, 0);
      check("rst_wori", bus.o_WorI, 0);
      check("rst_mode", bus.o_mode, 0);
      check("rst_row", bus.o_row_idx, 0);
      check("rst_col", bus.o_col_idx, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_err", bus.o_err, 0);
      rst = 1'b0;

      run_seq("m0",      3'd0, 10'd800, 10'd0,    -1,  -1, 1'b0, 815, 1'b0);
      run_seq("m4",      3'd4, 10'd3,   10'd100,  -1,  -1, 1'b0, 47,  1'b0);
      run_seq("m1stall", 3'd1, 10'd50,  10'd300,  30,  -1, 1'b0, 610, 1'b0);
      run_seq("illegal", 3'd6, 10'd10,  10'd10,   -1,  -1, 1'b0, 1,   1'b1);
      run_seq("abort",   3'd0, 10'd7,   10'd20,   -1, 200, 1'b0, 0,   1'b0);
      run_seq("restart", 3'd2, 10'd7,   10'd20,   -1,  -1, 1'b0, 175, 1'b0);
      run_seq("wrap",    3'd0, 10'd900, 10'd1000, -1,  -1, 1'b1, 815, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_buffer_ctrl.md
Name: ram_buffer_ctrl

Overview:
Sequencer for ram_buffer. Drives read_addr, en, WorI and mode through two phases:
- a 25-entry 5x5 weight preload (WorI=1);
- a raster scan of one size x size feature map (WorI=0).
It sits between the layer-level controller (start/done) and ram_buffer, so benches and top-level control no longer hand-generate address sweeps.

Parameters:
ADDR_WIDTH, 10, ram_buffer address width; all addresses wrap modulo 2^ADDR_WIDTH
KERNEL_TAPS, 25, number of weight reads per preload (5x5)
DRAIN_CYCLES, 4, idle cycles after the last feature-map read so ram_buffer/line-buffer outputs settle before done

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  synchronous cancel; any state -> IDLE
stall  in  1  backpressure; freezes read issue in WLOAD/FMAP
mode_in  in  3  feature-map select: 0=28, 1=24, 2=12, 3=8, 4=4; 5..7 illegal
weight_base  in  ADDR_WIDTH  first weight address
fmap_base  in  ADDR_WIDTH  first pixel address
read_addr  out  ADDR_WIDTH  to ram_buffer.read_addr
en  out  1  to ram_buffer.en; high only on cycles that issue a read
WorI  out  1  to ram_buffer.WorI; 1 = weight phase
mode  out  3  latched mode to ram_buffer.mode
row_idx  out  5  row of the pixel currently issued
col_idx  out  5  column of the pixel currently issued
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse at sequence end
err  out  1  one-cycle pulse, coincident with done, on illegal mode

Behaviour:
- All outputs are registered.
- Reset values: read_addr=0, en=0, WorI=0, mode=0, row_idx=0, col_idx=0, busy=0, done=0, err=0, state=IDLE.
- States: IDLE, WLOAD, GAP, FMAP, DRAIN, DONE.
- IDLE:
  - start=1 latches mode_in, weight_base and fmap_base.
  - If mode_in>4, go to DONE with err pending.
  - Otherwise go to WLOAD.
  - start in any other state is ignored.
- WLOAD:
  - Each non-stalled cycle drives en=1, WorI=1, read_addr=weight_base+k, for k=0..KERNEL_TAPS-1.
  - First read is on cycle 1 after start is sampled.
  - After k=24 is issued, go to GAP.
- GAP: exactly one cycle with en=0, WorI=0. Then go to FMAP.
- FMAP:
  - Each non-stalled cycle drives en=1, WorI=0, read_addr=fmap_base+row*S+col, where S = size(mode).
  - col increments each read; it wraps to 0 at S-1 and row increments.
  - After (S-1,S-1) is issued, go to DRAIN.
  - row_idx/col_idx track the issued pixel.
- DRAIN: en=0 for DRAIN_CYCLES cycles, then go to DONE.
- DONE:
  - done=1 for one cycle; err=1 if the illegal-mode path was taken.
  - busy=0 in the same cycle.
  - Next state is IDLE.
- Stall:
  - stall=1 in WLOAD/FMAP forces en=0.
  - Counters and read_addr hold.
  - The sequence resumes on the same address the cycle after stall falls.
  - Stall in other states has no effect.
- Abort: abort=1 in any state takes effect next cycle. State goes to IDLE, en=0, busy=0, no done/err pulse, counters cleared. abort has priority over start and stall.
- Address arithmetic:
  - Done at ADDR_WIDTH bits; overflow wraps.
  - S*S fits in 10 bits (max 784).
  - row*S+col is computed from incrementing counters; no multiplier is needed.
- Nominal latency for mode 0, no stall: start sampled at cycle 0; WLOAD cycles 1..25; GAP 26; FMAP 27..810; DRAIN 811..814; done at 815.
- mode output is held after the sequence ends, until the next accepted start.

Decomposition:
- Shared package: state encoding localparams; size lookup constants FMAP_SIZE_0..4 = 28, 24, 12, 8, 4; KERNEL_TAPS default.
- One natural sub-module, raster_addr_gen: row/col counters plus running address, with load, step and hold inputs. It is reused for both the weight phase (S=25, single row) and the pixel phase.

Test Plan:
1. Reset, then start with mode_in=0, weight_base=800, fmap_base=0, no stall. Required:
   - read_addr 800..824 with WorI=1;
   - one en=0 gap;
   - addresses 0..783 with WorI=0;
   - done at cycle 815; busy low afterwards.
2. mode_in=4, fmap_base=100. Required: 16 pixel reads at 100..115; row_idx/col_idx go (0,0)..(3,3); done at cycle 27+16+4=47.
3. Mode 1 with stall high for 3 cycles at FMAP read #30. Required: en=0 for those 3 cycles; read_addr holds at fmap_base+30; done is delayed by exactly 3 cycles.
4. mode_in=6. Required: no en pulse; done=1 and err=1 together on cycle 1; busy never asserts.
5. Abort during FMAP at pixel 200. Required: next cycle en=0, busy=0, no done. A subsequent start restarts cleanly at weight_base.
6. Start asserted while busy, and fmap_base=1000 in mode 0. Required: the extra start is ignored; addresses wrap (1000..1023, then 0..759).
